// File: rtl/host_rd_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM host-read port among NUM_REQ requesters,
// with an in-order tracking FIFO that steers response beats. Optional: HOST_RD_ARB_STATS_EN.
module host_rd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 512,
  parameter int BURST_W   = 3,
  parameter int TAG_DEPTH = 16
) (
  input  logic                       pClk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*BURST_W-1:0] req_burstcount,
  output logic [NUM_REQ-1:0]         req_waitrequest,
  output logic [NUM_REQ-1:0]         req_readdatavalid,
  output logic [DATA_W-1:0]          req_readdata,
  output logic                       host_read_read,
  output logic [ADDR_W-1:0]          host_read_address,
  output logic [BURST_W-1:0]         host_read_burstcount,
  input  logic                       host_read_waitrequest,
  input  logic                       host_read_readdatavalid,
  input  logic [DATA_W-1:0]          host_read_readdata,
  output logic                       err_unexpected_rsp,
  output logic                       err_bad_burst,
  output logic [NUM_REQ*32-1:0]      stat_grant_cnt,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a command transfers on a cycle where read=1 and waitrequest=0;
  // the requester holds read/address/burstcount stable until that cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_hr_read;
  logic [ADDR_W-1:0]    r_hr_addr;
  logic [BURST_W-1:0]   r_hr_burst;
  logic [IDX_W-1:0]     r_fifo_id  [TAG_DEPTH];
  logic [BURST_W-1:0]   r_fifo_len [TAG_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [BURST_W-1:0]   r_beat;
  logic                 r_err_unexp;
  logic                 r_err_bad;

  logic                 w_accept;
  logic                 w_not_full;
  logic                 w_fifo_empty;
  logic                 w_beat;
  logic                 w_pop;
  logic                 w_bad;
  logic [BURST_W-1:0]   w_store_len;
  logic [IDX_W-1:0]     w_head_id;
  logic [BURST_W-1:0]   w_head_len;
  logic                 w_found;
  logic [IDX_W-1:0]     w_winner;
  logic [NUM_REQ-1:0]   w_wait;
  logic [NUM_REQ-1:0]   w_rdv;

  assign w_accept     = (r_state == ST_GRANT) && !host_read_waitrequest;
  assign w_not_full   = r_count < CNT_W'(TAG_DEPTH);
  assign w_fifo_empty = (r_count == '0);
  assign w_beat       = host_read_readdatavalid && !w_fifo_empty;
  assign w_head_id    = r_fifo_id[r_rd_ptr];
  assign w_head_len   = r_fifo_len[r_rd_ptr];
  assign w_pop        = w_beat && ((r_beat + BURST_W'(1)) == w_head_len);
  assign w_bad        = (r_hr_burst == '0) || (r_hr_burst > BURST_W'(4));
  // A zero-length burst still occupies one beat so the entry can drain.
  assign w_store_len  = (r_hr_burst == '0) ? BURST_W'(1) : r_hr_burst;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_read[IDX_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_wait = '1;
    if (r_state == ST_GRANT) w_wait[r_grant] = host_read_waitrequest;
  end

  always_comb begin
    w_rdv = '0;
    if (w_beat) w_rdv[w_head_id] = 1'b1;
  end

  always_ff @(posedge pClk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_hr_read  <= 1'b0;
      r_hr_addr  <= '0;
      r_hr_burst <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_not_full) begin
            r_grant    <= w_winner;
            r_hr_read  <= 1'b1;
            r_hr_addr  <= req_address[int'(w_winner)*ADDR_W +: ADDR_W];
            r_hr_burst <= req_burstcount[int'(w_winner)*BURST_W +: BURST_W];
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_ptr     <= r_grant;
            r_hr_read <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (!req_read[r_grant]) begin
            r_hr_read <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_hr_read <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (w_accept) begin
      r_fifo_id[r_wr_ptr]  <= r_grant;
      r_fifo_len[r_wr_ptr] <= w_store_len;
    end
  end

  always_ff @(posedge pClk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_beat      <= '0;
      r_err_unexp <= 1'b0;
      r_err_bad   <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_beat) r_beat <= w_pop ? '0 : r_beat + BURST_W'(1);
      if (host_read_readdatavalid && w_fifo_empty) r_err_unexp <= 1'b1;
      if (w_accept && w_bad) r_err_bad <= 1'b1;
    end
  end

`ifdef HOST_RD_ARB_STATS_EN
  logic [31:0] r_stat [NUM_REQ];

  always_ff @(posedge pClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else if (w_accept) begin
      r_stat[r_grant] <= r_stat[r_grant] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_grant_cnt[gi*32 +: 32] = r_stat[gi];
  end
`else
  assign stat_grant_cnt = '0;
`endif

  assign req_waitrequest      = w_wait;
  assign req_readdatavalid    = w_rdv;
  assign req_readdata         = host_read_readdata;
  assign host_read_read       = r_hr_read;
  assign host_read_address    = r_hr_addr;
  assign host_read_burstcount = r_hr_burst;
  assign err_unexpected_rsp   = r_err_unexp;
  assign err_bad_burst        = r_err_bad;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_host_rd_arbiter.sv
// Self-checking bench for host_rd_arbiter: directed scenarios plus a randomized run
// against a transaction-level queue model of arbitration and response routing.
module tb_host_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int TD = 4;

  logic            pClk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read;
  logic [N*AW-1:0] req_address;
  logic [N*BW-1:0] req_burstcount;
  logic [N-1:0]    req_waitrequest;
  logic [N-1:0]    req_readdatavalid;
  logic [DW-1:0]   req_readdata;
  logic            host_read_read;
  logic [AW-1:0]   host_read_address;
  logic [BW-1:0]   host_read_burstcount;
  logic            host_read_waitrequest;
  logic            host_read_readdatavalid;
  logic [DW-1:0]   host_read_readdata;
  logic            err_unexpected_rsp;
  logic            err_bad_burst;
  logic [N*32-1:0] stat_grant_cnt;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;

  host_rd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TAG_DEPTH(TD)
  ) dut (
    .pClk(pClk), .reset(reset),
    .req_read(req_read), .req_address(req_address), .req_burstcount(req_burstcount),
    .req_waitrequest(req_waitrequest), .req_readdatavalid(req_readdatavalid),
    .req_readdata(req_readdata),
    .host_read_read(host_read_read), .host_read_address(host_read_address),
    .host_read_burstcount(host_read_burstcount),
    .host_read_waitrequest(host_read_waitrequest),
    .host_read_readdatavalid(host_read_readdatavalid),
    .host_read_readdata(host_read_readdata),
    .err_unexpected_rsp(err_unexpected_rsp), .err_bad_burst(err_bad_burst),
    .stat_grant_cnt(stat_grant_cnt), .dbg_state(dbg_state)
  );

  always #5 pClk = ~pClk;

  function automatic logic [31:0] exp_stat(input int v);
`ifdef HOST_RD_ARB_STATS_EN
    return 32'(v);
`else
    return 32'd0 & 32'(v);
`endif
  endfunction

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_read[i]               = rd;
    req_address[i*AW +: AW]   = a;
    req_burstcount[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_read = '0;
    req_address = '0;
    req_burstcount = '0;
    host_read_waitrequest = 1'b0;
    host_read_readdatavalid = 1'b0;
    host_read_readdata = $urandom;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_read = '0;
    req_address = '0;
    req_burstcount = '0;
    host_read_waitrequest = 1'b1;
    host_read_readdatavalid = 1'b1;
    host_read_readdata = 32'hA5A5_1234;
    tick();
    tick();
    checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %0h exp 0", host_read_read); end
    checks++; if (host_read_address !== '0) begin errors++; $display("FAIL rst_addr: got %0h exp 0", host_read_address); end
    checks++; if (host_read_burstcount !== '0) begin errors++; $display("FAIL rst_burst: got %0h exp 0", host_read_burstcount); end
    checks++; if (req_waitrequest !== 3'b111) begin errors++; $display("FAIL rst_wait: got %0b exp 111", req_waitrequest); end
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL rst_rdv: got %0b exp 000", req_readdatavalid); end
    checks++; if (req_readdata !== 32'hA5A5_1234) begin errors++; $display("FAIL rst_data: got %0h exp a5a51234", req_readdata); end
    checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL rst_err_unexp: got %0h exp 0", err_unexpected_rsp); end
    checks++; if (err_bad_burst !== 1'b0) begin errors++; $display("FAIL rst_err_bad: got %0h exp 0", err_bad_burst); end
    checks++; if (stat_grant_cnt !== '0) begin errors++; $display("FAIL rst_stat: got %0h exp 0", stat_grant_cnt); end
    host_read_readdatavalid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d;
    do_reset();
    set_req(0, 1'b1, 48'h1000, 3'd4);
    tick();
    checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL single_read: got %0h exp 1", host_read_read); end
    checks++; if (host_read_address !== 48'h1000) begin errors++; $display("FAIL single_addr: got %0h exp 1000", host_read_address); end
    checks++; if (host_read_burstcount !== 3'd4) begin errors++; $display("FAIL single_burst: got %0h exp 4", host_read_burstcount); end
    checks++; if (req_waitrequest !== 3'b110) begin errors++; $display("FAIL single_wait: got %0b exp 110", req_waitrequest); end
    tick();
    set_req(0, 1'b0, 48'h1000, 3'd4);
    checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL single_idle: got %0h exp 0", host_read_read); end
    checks++; if (err_bad_burst !== 1'b0) begin errors++; $display("FAIL single_badflag: got %0h exp 0", err_bad_burst); end
    for (int b = 0; b < 4; b++) begin
      d = $urandom;
      host_read_readdatavalid = 1'b1;
      host_read_readdata = d;
      #1;
      checks++; if (req_readdatavalid !== 3'b001) begin errors++; $display("FAIL single_rdv%0d: got %0b exp 001", b, req_readdatavalid); end
      checks++; if (req_readdata !== d) begin errors++; $display("FAIL single_data%0d: got %0h exp %0h", b, req_readdata, d); end
      tick();
    end
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL single_empty_rdv: got %0b exp 000", req_readdatavalid); end
    tick();
    host_read_readdatavalid = 1'b0;
    checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL single_empty_flag: got %0h exp 1", err_unexpected_rsp); end
  endtask

  task automatic test_fairness();
    int c[2];
    int w;
    c[0] = 0;
    c[1] = 0;
    do_reset();
    set_req(0, 1'b1, 48'hA000, 3'd1);
    set_req(1, 1'b1, 48'hB000, 3'd1);
    for (int n = 0; n < 8; n++) begin
      w = n % 2;
      tick();
      host_read_readdatavalid = 1'b0;
      checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL fair_read%0d: got %0h exp 1", n, host_read_read); end
      checks++; if (host_read_address !== (w ? 48'hB000 : 48'hA000)) begin errors++; $display("FAIL fair_winner%0d: got %0h exp %0h", n, host_read_address, (w ? 48'hB000 : 48'hA000)); end
      tick();
      c[w]++;
      host_read_readdatavalid = 1'b1;
      #1;
      checks++; if (req_readdatavalid !== (w ? 3'b010 : 3'b001)) begin errors++; $display("FAIL fair_rdv%0d: got %0b exp %0b", n, req_readdatavalid, (w ? 3'b010 : 3'b001)); end
      checks++; if (stat_grant_cnt[31:0] !== exp_stat(c[0])) begin errors++; $display("FAIL fair_stat0_%0d: got %0d exp %0d", n, stat_grant_cnt[31:0], exp_stat(c[0])); end
      checks++; if (stat_grant_cnt[63:32] !== exp_stat(c[1])) begin errors++; $display("FAIL fair_stat1_%0d: got %0d exp %0d", n, stat_grant_cnt[63:32], exp_stat(c[1])); end
    end
    tick();
    host_read_readdatavalid = 1'b0;
    req_read = '0;
  endtask

  task automatic test_stall();
    do_reset();
    set_req(1, 1'b1, 48'h2000, 3'd2);
    host_read_waitrequest = 1'b1;
    tick();
    for (int s = 0; s < 5; s++) begin
      checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL stall_read%0d: got %0h exp 1", s, host_read_read); end
      checks++; if (host_read_address !== 48'h2000) begin errors++; $display("FAIL stall_addr%0d: got %0h exp 2000", s, host_read_address); end
      checks++; if (host_read_burstcount !== 3'd2) begin errors++; $display("FAIL stall_burst%0d: got %0h exp 2", s, host_read_burstcount); end
      checks++; if (req_waitrequest !== 3'b111) begin errors++; $display("FAIL stall_wait%0d: got %0b exp 111", s, req_waitrequest); end
      tick();
    end
    host_read_waitrequest = 1'b0;
    #1;
    checks++; if (req_waitrequest !== 3'b101) begin errors++; $display("FAIL stall_release: got %0b exp 101", req_waitrequest); end
    tick();
    set_req(1, 1'b0, 48'h2000, 3'd2);
    checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL stall_done: got %0h exp 0", host_read_read); end
    host_read_readdatavalid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++; if (req_readdatavalid !== 3'b010) begin errors++; $display("FAIL stall_rdv%0d: got %0b exp 010", b, req_readdatavalid); end
      tick();
    end
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL stall_one_push: got %0b exp 000", req_readdatavalid); end
    tick();
    host_read_readdatavalid = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    set_req(0, 1'b1, 48'h3000, 3'd1);
    for (int n = 0; n < TD; n++) begin
      tick();
      checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL full_grant%0d: got %0h exp 1", n, host_read_read); end
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL full_block%0d: got %0h exp 0", s, host_read_read); end
    end
    host_read_readdatavalid = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b001) begin errors++; $display("FAIL full_rdv: got %0b exp 001", req_readdatavalid); end
    tick();
    host_read_readdatavalid = 1'b0;
    checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL full_pop_cycle: got %0h exp 0", host_read_read); end
    tick();
    checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL full_fifth: got %0h exp 1", host_read_read); end
    req_read = '0;
  endtask

  task automatic test_interleaved();
    logic [N-1:0] e;
    logic [DW-1:0] d;
    logic [1:0] exp_q[$];
    exp_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    do_reset();
    set_req(0, 1'b1, 48'h4000, 3'd2);
    set_req(1, 1'b1, 48'h5000, 3'd3);
    tick();
    checks++; if (host_read_address !== 48'h4000) begin errors++; $display("FAIL intl_addr0: got %0h exp 4000", host_read_address); end
    tick();
    set_req(0, 1'b0, 48'h4000, 3'd2);
    tick();
    checks++; if (host_read_address !== 48'h5000) begin errors++; $display("FAIL intl_addr1: got %0h exp 5000", host_read_address); end
    checks++; if (host_read_burstcount !== 3'd3) begin errors++; $display("FAIL intl_burst1: got %0h exp 3", host_read_burstcount); end
    tick();
    set_req(1, 1'b0, 48'h5000, 3'd3);
    while (exp_q.size() > 0) begin
      e = '0;
      e[exp_q.pop_front()] = 1'b1;
      d = $urandom;
      host_read_readdatavalid = 1'b1;
      host_read_readdata = d;
      #1;
      checks++; if (req_readdatavalid !== e) begin errors++; $display("FAIL intl_rdv: got %0b exp %0b", req_readdatavalid, e); end
      checks++; if (req_readdata !== d) begin errors++; $display("FAIL intl_data: got %0h exp %0h", req_readdata, d); end
      tick();
    end
    host_read_readdatavalid = 1'b0;
  endtask

  task automatic test_unexpected_reset();
    do_reset();
    host_read_readdatavalid = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL unexp_rdv: got %0b exp 000", req_readdatavalid); end
    tick();
    host_read_readdatavalid = 1'b0;
    checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL unexp_flag: got %0h exp 1", err_unexpected_rsp); end
    set_req(2, 1'b1, 48'h6000, 3'd4);
    tick();
    checks++; if (host_read_address !== 48'h6000) begin errors++; $display("FAIL unexp_addr2: got %0h exp 6000", host_read_address); end
    tick();
    set_req(2, 1'b0, 48'h6000, 3'd4);
    host_read_readdatavalid = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b100) begin errors++; $display("FAIL unexp_route2: got %0b exp 100", req_readdatavalid); end
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL midrst_rdv: got %0b exp 000", req_readdatavalid); end
    checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL midrst_flag: got %0h exp 0", err_unexpected_rsp); end
    checks++; if (host_read_address !== '0) begin errors++; $display("FAIL midrst_addr: got %0h exp 0", host_read_address); end
    checks++; if (host_read_burstcount !== '0) begin errors++; $display("FAIL midrst_burst: got %0h exp 0", host_read_burstcount); end
    checks++; if (req_waitrequest !== 3'b111) begin errors++; $display("FAIL midrst_wait: got %0b exp 111", req_waitrequest); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL postrst_rdv: got %0b exp 000", req_readdatavalid); end
    tick();
    host_read_readdatavalid = 1'b0;
  endtask

  task automatic test_bad_burst();
    do_reset();
    set_req(0, 1'b1, 48'h7000, 3'd0);
    tick();
    checks++; if (host_read_burstcount !== 3'd0) begin errors++; $display("FAIL bad_fwd0: got %0h exp 0", host_read_burstcount); end
    tick();
    set_req(0, 1'b0, 48'h7000, 3'd0);
    checks++; if (err_bad_burst !== 1'b1) begin errors++; $display("FAIL bad_flag0: got %0h exp 1", err_bad_burst); end
    host_read_readdatavalid = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b001) begin errors++; $display("FAIL bad_len1_rdv: got %0b exp 001", req_readdatavalid); end
    tick();
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL bad_len1_pop: got %0b exp 000", req_readdatavalid); end
    host_read_readdatavalid = 1'b0;
    do_reset();
    set_req(1, 1'b1, 48'h7100, 3'd6);
    tick();
    checks++; if (host_read_burstcount !== 3'd6) begin errors++; $display("FAIL bad_fwd6: got %0h exp 6", host_read_burstcount); end
    tick();
    set_req(1, 1'b0, 48'h7100, 3'd6);
    checks++; if (err_bad_burst !== 1'b1) begin errors++; $display("FAIL bad_flag6: got %0h exp 1", err_bad_burst); end
  endtask

  task automatic test_drop();
    do_reset();
    set_req(0, 1'b1, 48'h8000, 3'd1);
    host_read_waitrequest = 1'b1;
    tick();
    checks++; if (host_read_read !== 1'b1) begin errors++; $display("FAIL drop_grant: got %0h exp 1", host_read_read); end
    set_req(0, 1'b0, 48'h8000, 3'd1);
    tick();
    checks++; if (host_read_read !== 1'b0) begin errors++; $display("FAIL drop_abort: got %0h exp 0", host_read_read); end
    host_read_waitrequest = 1'b0;
    host_read_readdatavalid = 1'b1;
    #1;
    checks++; if (req_readdatavalid !== 3'b000) begin errors++; $display("FAIL drop_nopush: got %0b exp 000", req_readdatavalid); end
    checks++; if (stat_grant_cnt !== '0) begin errors++; $display("FAIL drop_stat: got %0h exp 0", stat_grant_cnt); end
    tick();
    host_read_readdatavalid = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] m_addr[N];
    logic [BW-1:0] m_burst[N];
    bit            m_pend[N];
    int            stat[N];
    logic [1:0]    exp_q[$];
    int            len_q[$];
    bit            busy, e_unexp, e_bad, found, hw, hv;
    int            g, ptr, beats, cnt0, idx, r;
    logic [DW-1:0] hd;
    logic [N-1:0]  exp_wait, exp_rdv;
    do_reset();
    busy = 0; e_unexp = 0; e_bad = 0; g = 0; ptr = N - 1; beats = 0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; stat[i] = 0; m_addr[i] = '0; m_burst[i] = '0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && $urandom_range(0, 2) == 0) begin
          m_pend[i] = 1;
          m_addr[i] = {$urandom, $urandom};
          r = $urandom_range(0, 19);
          m_burst[i] = (r == 0) ? BW'(0) : (r == 1) ? BW'($urandom_range(5, 7)) : BW'($urandom_range(1, 4));
        end
        set_req(i, m_pend[i], m_addr[i], m_burst[i]);
      end
      hw = ($urandom_range(0, 2) == 0);
      hv = (exp_q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
      hd = $urandom;
      host_read_waitrequest = hw;
      host_read_readdatavalid = hv;
      host_read_readdata = hd;
      #1;
      exp_wait = '1;
      if (busy) exp_wait[g] = hw;
      exp_rdv = '0;
      if (hv && exp_q.size() > 0) exp_rdv[exp_q[0]] = 1'b1;
      checks++; if (host_read_read !== busy) begin errors++; $display("FAIL rnd_read c%0d: got %0h exp %0h", cyc, host_read_read, busy); end
      if (busy) begin
        checks++; if (host_read_address !== m_addr[g]) begin errors++; $display("FAIL rnd_addr c%0d: got %0h exp %0h", cyc, host_read_address, m_addr[g]); end
        checks++; if (host_read_burstcount !== m_burst[g]) begin errors++; $display("FAIL rnd_burst c%0d: got %0h exp %0h", cyc, host_read_burstcount, m_burst[g]); end
      end
      checks++; if (req_waitrequest !== exp_wait) begin errors++; $display("FAIL rnd_wait c%0d: got %0b exp %0b", cyc, req_waitrequest, exp_wait); end
      checks++; if (req_readdatavalid !== exp_rdv) begin errors++; $display("FAIL rnd_rdv c%0d: got %0b exp %0b", cyc, req_readdatavalid, exp_rdv); end
      checks++; if (req_readdata !== hd) begin errors++; $display("FAIL rnd_data c%0d: got %0h exp %0h", cyc, req_readdata, hd); end
      cnt0 = exp_q.size();
      if (hv) begin
        if (cnt0 > 0) begin
          beats++;
          if (beats == len_q[0]) begin
            void'(exp_q.pop_front());
            void'(len_q.pop_front());
            beats = 0;
          end
        end else e_unexp = 1;
      end
      if (busy) begin
        if (!hw) begin
          exp_q.push_back(2'(g));
          len_q.push_back((m_burst[g] == 0) ? 1 : int'(m_burst[g]));
          if (m_burst[g] == 0 || m_burst[g] > 4) e_bad = 1;
          stat[g]++;
          ptr = g;
          m_pend[g] = 0;
          busy = 0;
        end
      end else if (cnt0 < TD) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (ptr + k) % N;
          if (!found && m_pend[idx]) begin found = 1; busy = 1; g = idx; end
        end
      end
      tick();
      checks++; if (err_unexpected_rsp !== e_unexp) begin errors++; $display("FAIL rnd_err_unexp c%0d: got %0h exp %0h", cyc, err_unexpected_rsp, e_unexp); end
      checks++; if (err_bad_burst !== e_bad) begin errors++; $display("FAIL rnd_err_bad c%0d: got %0h exp %0h", cyc, err_bad_burst, e_bad); end
      for (int i = 0; i < N; i++) begin
        checks++; if (stat_grant_cnt[i*32 +: 32] !== exp_stat(stat[i])) begin errors++; $display("FAIL rnd_stat%0d c%0d: got %0d exp %0d", i, cyc, stat_grant_cnt[i*32 +: 32], exp_stat(stat[i])); end
      end
    end
    host_read_readdatavalid = 1'b0;
    req_read = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fairness();
    test_stall();
    test_full();
    test_interleaved();
    test_unexpected_reset();
    test_bad_burst();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
